// File: rtl/vproc_result_rob_pkg.sv
// Shared types for the XIF result reorder buffer: the stored entry layout and depth helper.
package vproc_result_rob_pkg;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    logic [5:0]  exccode;
  } rob_entry_t;

  function automatic int unsigned rob_depth(input int unsigned id_w);
    return 32'd1 << id_w;
  endfunction

endpackage

// File: rtl/vproc_result_rob_if.sv
// Result write channel (producer -> ROB) and in-order result channel (ROB -> XIF result stage).
interface vproc_result_rob_if #(
  parameter int unsigned XIF_ID_W = 3
);

  logic                wr_valid;
  logic                wr_ready;
  logic [XIF_ID_W-1:0] wr_id;
  logic                wr_we;
  logic [4:0]          wr_rd;
  logic [31:0]         wr_data;
  logic                wr_exc;
  logic [5:0]          wr_exccode;

  logic                res_valid;
  logic                res_ready;
  logic [XIF_ID_W-1:0] res_id;
  logic                res_we;
  logic [4:0]          res_rd;
  logic [31:0]         res_data;
  logic                res_exc;
  logic [5:0]          res_exccode;

  modport slave (
    input  wr_valid, wr_id, wr_we, wr_rd, wr_data, wr_exc, wr_exccode,
    output wr_ready,
    output res_valid, res_id, res_we, res_rd, res_data, res_exc, res_exccode,
    input  res_ready
  );

  modport master (
    output wr_valid, wr_id, wr_we, wr_rd, wr_data, wr_exc, wr_exccode,
    input  wr_ready,
    input  res_valid, res_id, res_we, res_rd, res_data, res_exc, res_exccode,
    output res_ready
  );

endinterface

// File: rtl/vproc_result_rob.sv
// Per-ID result reorder buffer: accepts results in any ID order, retires them strictly in ID order.
// Optional same-cycle bypass of a head write to the result port: define VPROC_RESULT_ROB_BYPASS_EN.
module vproc_result_rob
  import vproc_result_rob_pkg::*;
#(
  parameter int unsigned XIF_ID_W       = 3,
  parameter bit          DONT_CARE_ZERO = 1'b0
) (
  input  logic                clk_i,
  input  logic                async_rst_ni,
  input  logic                sync_rst_ni,
  input  logic                flush_i,
  vproc_result_rob_if.slave   rob_if,
  output logic [XIF_ID_W-1:0] head_id_o,
  output logic [XIF_ID_W:0]   occupancy_o
);

  localparam int unsigned DEPTH = rob_depth(XIF_ID_W);
  localparam int unsigned OCC_W = XIF_ID_W + 1;

  typedef logic [XIF_ID_W-1:0] id_t;

  rob_entry_t       mem_q [DEPTH];
  logic [DEPTH-1:0] full_q, full_d;
  id_t              head_q, head_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  rob_entry_t wr_entry, head_entry, dc_entry, res_entry;
  logic       head_full, head_hit, bypass;
  logic       res_valid, pop, wr_ready, wr_fire, store;

  assign wr_entry = '{
    we:      rob_if.wr_we,
    rd:      rob_if.wr_rd,
    data:    rob_if.wr_data,
    exc:     rob_if.wr_exc,
    exccode: rob_if.wr_exccode
  };

  assign dc_entry = DONT_CARE_ZERO ? rob_entry_t'('0) : rob_entry_t'('x);

  assign head_full = full_q[head_q];
  assign head_hit  = (rob_if.wr_id == head_q);

`ifdef VPROC_RESULT_ROB_BYPASS_EN
  // A write to an empty head slot is offered straight to the result port.
  assign bypass = ~flush_i & rob_if.wr_valid & head_hit & ~head_full;
`else
  assign bypass = 1'b0;
`endif

  // Flush blocks both handshakes for the whole cycle.
  assign res_valid = ~flush_i & (head_full | bypass);
  assign pop       = res_valid & rob_if.res_ready;
  assign wr_ready  = ~flush_i & (~full_q[rob_if.wr_id] | (pop & head_hit));
  assign wr_fire   = rob_if.wr_valid & wr_ready;
  // A bypassed write that is consumed immediately never occupies its slot.
  assign store     = wr_fire & ~(bypass & pop);

  assign head_entry = bypass ? wr_entry : mem_q[head_q];
  assign res_entry  = res_valid ? head_entry : dc_entry;

  assign rob_if.wr_ready    = wr_ready;
  assign rob_if.res_valid   = res_valid;
  assign rob_if.res_id      = res_valid ? head_q : (DONT_CARE_ZERO ? id_t'('0) : id_t'('x));
  assign rob_if.res_we      = res_entry.we;
  assign rob_if.res_rd      = res_entry.rd;
  assign rob_if.res_data    = res_entry.data;
  assign rob_if.res_exc     = res_entry.exc;
  assign rob_if.res_exccode = res_entry.exccode;

  assign head_id_o   = head_q;
  assign occupancy_o = occ_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    full_d = full_q;
    head_d = head_q;
    occ_d  = occ_q;

    if (flush_i) begin
      full_d = '0;
      occ_d  = '0;
    end else begin
      // Clear on pop before set on store: pop and refill of one slot leaves it full.
      if (pop) begin
        full_d[head_q] = 1'b0;
      end
      if (store) begin
        full_d[rob_if.wr_id] = 1'b1;
      end
      occ_d = occ_q + OCC_W'(wr_fire) - OCC_W'(pop);
    end

    if (pop) begin
      head_d = head_q + id_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      full_q <= '0;
      head_q <= '0;
      occ_q  <= '0;
    end else if (!sync_rst_ni) begin
      full_q <= '0;
      head_q <= '0;
      occ_q  <= '0;
    end else begin
      full_q <= full_d;
      head_q <= head_d;
      occ_q  <= occ_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; a slot's contents only matter while its full bit is set.
  always_ff @(posedge clk_i) begin
    if (store) begin
      mem_q[rob_if.wr_id] <= wr_entry;
    end
  end

endmodule
